// File: rtl/text_pkg.sv
// ---------------------------------------------------------------------------
// text_pkg
// Shared definitions for the text cursor controller: grid geometry, default
// placement parameters, ASCII control codes, FSM state type and the
// logical-to-physical column mapping.
// ---------------------------------------------------------------------------
package text_pkg;

    localparam int unsigned ROWS           = 4;
    localparam int unsigned COLS           = 32;
    localparam int unsigned SWEEP_W        = $clog2(ROWS * COLS);
    localparam int unsigned DEF_COL_OFFSET = 24;
    localparam int unsigned DEF_HOME_ROW   = 1;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Physical column = (logical + offset) mod COLS.
    function automatic logic [4:0] phys_col(input logic [4:0] lcol,
                                            input int unsigned offset);
        phys_col = 5'((32'(lcol) + offset) % COLS);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// ---------------------------------------------------------------------------
// byte_fifo
// Synchronous show-ahead byte queue. dout always presents the oldest entry
// while empty is low. A push while full is accepted only when a pop happens
// in the same cycle. flush empties the queue and ignores same-cycle push/pop.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous active-low reset
//   flush  in   discard all entries
//   push   in   write din
//   pop    in   consume oldest entry
//   din    in   8-bit write data
//   dout   out  8-bit oldest entry (show-ahead)
//   full   out  queue holds DEPTH entries
//   empty  out  queue holds no entries
// ---------------------------------------------------------------------------
module byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/text_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// text_cursor_ctrl
// Turns a stream of received UART bytes into text-RAM writes on a 4x32 grid,
// tracking a cursor and performing clear-screen sweeps.
//
// Build option: define TEXT_CURSOR_BACKSPACE_EN to enable 0x08 backspace
// handling; otherwise 0x08 is discarded like other control bytes.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   rx_valid  in   rx_data strobe
//   rx_data   in   received byte
//   clear     in   clear-screen request (flushes queue, restarts sweep)
//   wr_en     out  text-RAM write strobe
//   wr_row    out  write row
//   wr_col    out  write physical column
//   wr_data   out  write byte
//   cur_row   out  cursor row
//   cur_col   out  cursor physical column
//   busy      out  clear sweep write in progress
//   overflow  out  sticky: byte dropped on a full queue
// ---------------------------------------------------------------------------
module text_cursor_ctrl
    import text_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned COL_OFFSET = DEF_COL_OFFSET,
    parameter int unsigned HOME_ROW   = DEF_HOME_ROW
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       clear,
    output logic       wr_en,
    output logic [1:0] wr_row,
    output logic [4:0] wr_col,
    output logic [7:0] wr_data,
    output logic [1:0] cur_row,
    output logic [4:0] cur_col,
    output logic       busy,
    output logic       overflow
);

    state_t             state;
    logic [SWEEP_W-1:0] sweep;
    logic [1:0]         row;
    logic [4:0]         lcol;

    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_dout;

    // Decode of the byte at the head of the queue against the current cursor.
    logic       d_wr;
    logic       d_clear;
    logic [4:0] d_col;
    logic [7:0] d_data;
    logic [1:0] n_row;
    logic [4:0] n_col;

    assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !clear;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (rx_valid),
        .pop   (fifo_pop),
        .din   (rx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        d_wr    = 1'b0;
        d_clear = 1'b0;
        d_col   = lcol;
        d_data  = fifo_dout;
        n_row   = row;
        n_col   = lcol;
        if (fifo_dout >= ASCII_SPACE && fifo_dout <= ASCII_TILDE) begin
            d_wr  = 1'b1;
            n_col = lcol + 5'd1;
            if (lcol == 5'd31) n_row = row + 2'd1;
        end else if (fifo_dout == ASCII_CR || fifo_dout == ASCII_LF) begin
            n_col = '0;
            n_row = row + 2'd1;
        end else if (fifo_dout == ASCII_FF) begin
            d_clear = 1'b1;
`ifdef TEXT_CURSOR_BACKSPACE_EN
        end else if (fifo_dout == ASCII_BS && lcol != 5'd0) begin
            d_wr   = 1'b1;
            d_col  = lcol - 5'd1;
            d_data = ASCII_SPACE;
            n_col  = lcol - 5'd1;
`endif
        end
    end

    // The cursor state updates at the pop edge so back-to-back bytes see it
    // immediately; cur_row/cur_col are a registered copy one cycle later.
    // Sweep cell 0 is written on the edge that starts the sweep, so CLEAR
    // only covers cells 1..127.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            sweep    <= '0;
            row      <= 2'(HOME_ROW);
            lcol     <= '0;
            wr_en    <= 1'b0;
            wr_row   <= '0;
            wr_col   <= '0;
            wr_data  <= '0;
            cur_row  <= 2'(HOME_ROW);
            cur_col  <= phys_col(5'd0, COL_OFFSET);
            busy     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            cur_row <= row;
            cur_col <= phys_col(lcol, COL_OFFSET);
            if (clear) begin
                state    <= ST_CLEAR;
                sweep    <= SWEEP_W'(1);
                wr_en    <= 1'b1;
                wr_row   <= '0;
                wr_col   <= '0;
                wr_data  <= ASCII_SPACE;
                busy     <= 1'b1;
                overflow <= 1'b0;
            end else begin
                if (rx_valid && fifo_full && !fifo_pop) overflow <= 1'b1;
                case (state)
                    ST_IDLE: begin
                        wr_en <= 1'b0;
                        busy  <= 1'b0;
                        if (fifo_pop) begin
                            if (d_clear) begin
                                state   <= ST_CLEAR;
                                sweep   <= SWEEP_W'(1);
                                wr_en   <= 1'b1;
                                wr_row  <= '0;
                                wr_col  <= '0;
                                wr_data <= ASCII_SPACE;
                                busy    <= 1'b1;
                            end else begin
                                wr_en   <= d_wr;
                                wr_row  <= row;
                                wr_col  <= phys_col(d_col, COL_OFFSET);
                                wr_data <= d_data;
                                row     <= n_row;
                                lcol    <= n_col;
                            end
                        end
                    end
                    ST_CLEAR: begin
                        wr_en   <= 1'b1;
                        wr_row  <= sweep[6:5];
                        wr_col  <= sweep[4:0];
                        wr_data <= ASCII_SPACE;
                        busy    <= 1'b1;
                        sweep   <= sweep + 1'b1;
                        if (sweep == '1) begin
                            state <= ST_IDLE;
                            row   <= 2'(HOME_ROW);
                            lcol  <= '0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
